// File: rtl/stack_arbiter_if.sv
// ---------------------------------------------------------------------------
// stack_arbiter_if
//   Bundles the two requester ports and the push-down-stack control/status
//   wires seen by stack_arbiter.
//
//   Requester side : req0/req1, op0/op1 (0 push, 1 pop), wdata0/wdata1,
//                    ack0/ack1, err0/err1, rdata0/rdata1
//   Stack side     : stk_PushPop, stk_En, stk_data_i (to the stack),
//                    stk_data_o, stk_empty, stk_full (from the stack)
//
//   slave  : the arbiter's view (requests and stack status in, responses and
//            stack controls out)
//   master : the environment's view (requesters plus the stack instance)
// ---------------------------------------------------------------------------
interface stack_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  op0;
  logic                  op1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  err0;
  logic                  err1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  stk_PushPop;
  logic                  stk_En;
  logic [DATA_WIDTH-1:0] stk_data_i;
  logic [DATA_WIDTH-1:0] stk_data_o;
  logic                  stk_empty;
  logic                  stk_full;

  modport slave (
    input  req0, req1, op0, op1, wdata0, wdata1,
    input  stk_data_o, stk_empty, stk_full,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output stk_PushPop, stk_En, stk_data_i
  );

  modport master (
    output req0, req1, op0, op1, wdata0, wdata1,
    output stk_data_o, stk_empty, stk_full,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  stk_PushPop, stk_En, stk_data_i
  );
endinterface

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
//   Round-robin arbiter/sequencer placing push/pop requests from two
//   requesters onto a single PushDownStack control interface. Each accepted
//   operation produces exactly one stk_En pulse; rejected operations (push on
//   full, pop on empty) never touch the stack. Every operation ends with a
//   one-cycle ack (plus err) to the requester that owned it; popped words are
//   held per port in rdata0/rdata1.
//
//   Ports:
//     Clk  - single clock, rising edge
//     Rst  - synchronous active-high reset (shared with the stack)
//     bus  - stack_arbiter_if.slave: requester handshakes and stack wires
//
//   All outputs come straight from flops, so nothing on the stack side
//   depends combinationally on req/op/wdata.
// ---------------------------------------------------------------------------
module stack_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  stack_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q,  state_d;
  logic                  id_q,     id_d;      // owner of the current operation
  logic                  op_q,     op_d;      // 0 push, 1 pop
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic                  err_q,    err_d;
  logic                  last_q,   last_d;    // most recently served port
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q,   ack0_d;
  logic                  ack1_q,   ack1_d;
  logic                  err0_q,   err0_d;
  logic                  err1_q,   err1_d;
  logic                  en_q,     en_d;
  logic                  pp_q,     pp_d;

  logic                  win_s;
  logic                  reject_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win_s    = 1'b0;
    reject_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the port that was not served last wins.
          if (bus.req0 && bus.req1) begin
            win_s = ~last_q;
          end else if (bus.req1) begin
            win_s = 1'b1;
          end else begin
            win_s = 1'b0;
          end
          id_d    = win_s;
          op_d    = win_s ? bus.op1 : bus.op0;
          wdata_d = win_s ? bus.wdata1 : bus.wdata0;
          // Flags are only consulted here; nothing else drives the stack,
          // so they cannot change until this arbiter issues an operation.
          reject_s = op_d ? bus.stk_empty : bus.stk_full;
          if (reject_s) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = op_q ? CAPT : RESP;
      end
      CAPT: begin
        // The stack updated data_o on the ISSUE edge; capture it now.
        if (id_q) begin
          rdata1_d = bus.stk_data_o;
        end else begin
          rdata0_d = bus.stk_data_o;
        end
        state_d = RESP;
      end
      RESP: begin
        last_d  = id_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state so the flops present them
    // during the state they belong to.
    en_d   = (state_d == ISSUE);
    pp_d   = (state_d == ISSUE) && op_d;
    ack0_d = (state_d == RESP) && !id_d;
    ack1_d = (state_d == RESP) &&  id_d;
    err0_d = ack0_d && err_d;
    err1_d = ack1_d && err_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      op_q     <= 1'b0;
      wdata_q  <= {DATA_WIDTH{1'b0}};
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= {DATA_WIDTH{1'b0}};
      rdata1_q <= {DATA_WIDTH{1'b0}};
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      en_q     <= 1'b0;
      pp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      en_q     <= en_d;
      pp_q     <= pp_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.stk_En      = en_q;
  assign bus.stk_PushPop = pp_q;
  assign bus.stk_data_i  = wdata_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stack_arbiter
//   Drives stack_arbiter with directed and random requests, hosts a small
//   behavioural push-down stack on the stack side, and checks every response
//   against a queue-based reference of stack contents and per-port rdata.
// ---------------------------------------------------------------------------
module tb_stack_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  stack_arbiter_if #(.DATA_WIDTH(DW)) ifc ();
  stack_arbiter #(.DATA_WIDTH(DW)) dut (.Clk(Clk), .Rst(Rst), .bus(ifc));

  int vectors     = 0;
  int miscompares = 0;

  // Requester drive
  logic          req_s [2];
  logic          op_s  [2];
  logic [DW-1:0] wd_s  [2];
  assign ifc.req0   = req_s[0];
  assign ifc.req1   = req_s[1];
  assign ifc.op0    = op_s[0];
  assign ifc.op1    = op_s[1];
  assign ifc.wdata0 = wd_s[0];
  assign ifc.wdata1 = wd_s[1];

  // Behavioural stack attached to the arbiter
  logic [DW-1:0] mem [DEPTH];
  int            cnt = 0;
  logic [DW-1:0] dout;
  always @(posedge Clk) begin
    if (Rst) begin
      cnt  <= 0;
      dout <= '0;
    end else if (ifc.stk_En) begin
      if (ifc.stk_PushPop) begin
        if (cnt > 0) begin
          dout <= mem[cnt-1];
          cnt  <= cnt - 1;
        end
      end else if (cnt < DEPTH) begin
        mem[cnt] <= ifc.stk_data_i;
        cnt      <= cnt + 1;
      end
    end
  end
  assign ifc.stk_data_o = dout;
  assign ifc.stk_empty  = (cnt == 0);
  assign ifc.stk_full   = (cnt == DEPTH);

  // Reference model state
  logic [DW-1:0] rq [$];
  logic [DW-1:0] exp_rd [2];
  int            en_count = 0;
  int            last_g   = 1;
  int            glog [$];
  bit            mon_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ackv(input int p);
    return (p == 1) ? ifc.ack1 : ifc.ack0;
  endfunction

  function automatic logic errv(input int p);
    return (p == 1) ? ifc.err1 : ifc.err0;
  endfunction

  // Expected cycles from request sampling to ack, from the reference contents
  function automatic int pred_lat(input logic op);
    if (op) return (rq.size() == 0) ? 1 : 3;
    else    return (rq.size() == DEPTH) ? 1 : 2;
  endfunction

  function automatic void ref_reset();
    rq.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_g    = 1;
  endfunction

  // Scoreboard: applies each ack to the reference stack in grant order
  always @(posedge Clk) begin : mon
    logic e;
    #1;
    if (mon_on && !Rst) begin
      chk("dual_ack", {31'd0, ifc.ack0 & ifc.ack1}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (ackv(p)) begin
          glog.push_back(p);
          last_g = p;
          if (op_s[p]) begin
            e = (rq.size() == 0);
            chk("err_pop", {31'd0, errv(p)}, {31'd0, e});
            if (!e) exp_rd[p] = rq.pop_back();
          end else begin
            e = (rq.size() == DEPTH);
            chk("err_push", {31'd0, errv(p)}, {31'd0, e});
            if (!e) rq.push_back(wd_s[p]);
          end
        end
      end
      chk("rdata0", {24'd0, ifc.rdata0}, {24'd0, exp_rd[0]});
      chk("rdata1", {24'd0, ifc.rdata1}, {24'd0, exp_rd[1]});
      if (ifc.stk_En) en_count++;
      else chk("pushpop_idle", {31'd0, ifc.stk_PushPop}, 32'd0);
    end
  end

  // One operation on port p; call in an IDLE cycle at posedge+#2, returns
  // one cycle after the ack (arbiter back in IDLE)
  task automatic do_op(input int p, input logic op, input logic [DW-1:0] d, output int lat);
    op_s[p]  = op;
    wd_s[p]  = d;
    req_s[p] = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk); #2;
      lat++;
      if (ackv(p)) break;
    end
    chk("ack_seen", {31'd0, ackv(p)}, 32'd1);
    req_s[p] = 1'b0;
    @(posedge Clk); #2;
  endtask

  task automatic exp_op(input int p, input logic op, input logic [DW-1:0] d, input string tag);
    int lat;
    int want;
    want = pred_lat(op);
    do_op(p, op, d, lat);
    chk(tag, lat, want);
  endtask

  // Back-to-back requests keeping req high between operations
  task automatic stream(input int p, input int n, input bit rnd, input logic [DW-1:0] d);
    int k;
    for (int i = 0; i < n; i++) begin
      op_s[p]  = rnd ? 1'($urandom_range(0, 1)) : 1'(i % 2);
      wd_s[p]  = rnd ? 8'($urandom) : d;
      req_s[p] = 1'b1;
      k = 0;
      while (k < 40) begin
        @(posedge Clk); #2;
        k++;
        if (ackv(p)) break;
      end
      chk("stream_ack", {31'd0, ackv(p)}, 32'd1);
    end
    req_s[p] = 1'b0;
    @(posedge Clk); #2;
  endtask

  initial begin
    int lat;
    int en0;
    int g0;
    int want;
    logic [DW-1:0] lastw;

    req_s[0] = 1'b0; req_s[1] = 1'b0;
    op_s[0]  = 1'b0; op_s[1]  = 1'b0;
    wd_s[0]  = '0;   wd_s[1]  = '0;

    // Reset: two cycles, then all outputs idle
    Rst = 1'b1;
    ref_reset();
    repeat (2) @(posedge Clk);
    #2;
    Rst = 1'b0;
    chk("rst_ack",  {30'd0, ifc.ack1, ifc.ack0}, 32'd0);
    chk("rst_err",  {30'd0, ifc.err1, ifc.err0}, 32'd0);
    chk("rst_rd",   {16'd0, ifc.rdata1, ifc.rdata0}, 32'd0);
    chk("rst_stk",  {30'd0, ifc.stk_En, ifc.stk_PushPop}, 32'd0);
    chk("rst_din",  {24'd0, ifc.stk_data_i}, 32'd0);
    chk("rst_empty", {31'd0, ifc.stk_empty}, 32'd1);
    mon_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #2;
      chk("idle_ack", {30'd0, ifc.ack1, ifc.ack0}, 32'd0);
    end

    // Pop on empty from requester 1
    en0 = en_count;
    do_op(1, 1'b1, 8'h00, lat);
    chk("pop_empty_lat", lat, 1);
    chk("pop_empty_en", en_count - en0, 0);
    chk("pop_empty_rd1", {24'd0, ifc.rdata1}, 32'd0);

    // Single-port sequence on requester 0
    en0 = en_count;
    exp_op(0, 1'b0, 8'd115, "push115_lat");
    exp_op(0, 1'b0, 8'd123, "push123_lat");
    do_op(0, 1'b1, 8'h00, lat);
    chk("pop1_lat", lat, 3);
    chk("pop1_rd", {24'd0, ifc.rdata0}, 32'd123);
    do_op(0, 1'b1, 8'h00, lat);
    chk("pop2_lat", lat, 3);
    chk("pop2_rd", {24'd0, ifc.rdata0}, 32'd115);
    chk("seq_en_cnt", en_count - en0, 4);

    // Contention from reset release: push 10/20, then pop
    Rst = 1'b1;
    ref_reset();
    glog.delete();
    fork
      stream(0, 2, 1'b0, 8'd10);
      stream(1, 2, 1'b0, 8'd20);
      begin
        repeat (2) @(posedge Clk);
        #2;
        Rst = 1'b0;
      end
    join
    chk("cont_grants", glog.size(), 4);
    for (int i = 0; i < glog.size(); i++) begin
      want = i % 2;
      chk("cont_order", glog[i], want);
    end
    chk("cont_rd0", {24'd0, ifc.rdata0}, 32'd20);
    chk("cont_rd1", {24'd0, ifc.rdata1}, 32'd10);

    // Full: fill, reject push of 55, pop the last accepted word
    for (int i = 0; i < DEPTH; i++) begin
      lastw = 8'($urandom_range(60, 250));
      exp_op(0, 1'b0, lastw, "fill_lat");
    end
    chk("full_flag", {31'd0, ifc.stk_full}, 32'd1);
    en0 = en_count;
    do_op(0, 1'b0, 8'd55, lat);
    chk("full_lat", lat, 1);
    chk("full_en", en_count - en0, 0);
    do_op(0, 1'b1, 8'h00, lat);
    chk("after_full_rd", {24'd0, ifc.rdata0}, {24'd0, lastw});

    // Reset during CAPT of a pop: no ack, then normal service
    op_s[0]  = 1'b1;
    req_s[0] = 1'b1;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    chk("capt_ack", {31'd0, ifc.ack0}, 32'd0);
    Rst = 1'b1;
    ref_reset();
    req_s[0] = 1'b0;
    @(posedge Clk); #2;
    chk("midrst_ack", {30'd0, ifc.ack1, ifc.ack0}, 32'd0);
    chk("midrst_en", {31'd0, ifc.stk_En}, 32'd0);
    @(posedge Clk); #2;
    Rst = 1'b0;
    chk("midrst_rd0", {24'd0, ifc.rdata0}, 32'd0);
    exp_op(0, 1'b0, 8'd7, "push7_lat");
    do_op(0, 1'b1, 8'h00, lat);
    chk("pop7_lat", lat, 3);
    chk("pop7_rd", {24'd0, ifc.rdata0}, 32'd7);

    // Random single-requester traffic
    for (int i = 0; i < 40; i++) begin
      exp_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand_lat");
    end

    // Random concurrent traffic: grants must alternate strictly
    g0 = last_g;
    glog.delete();
    fork
      stream(0, 12, 1'b1, 8'h00);
      stream(1, 12, 1'b1, 8'h00);
    join
    chk("rc_grants", glog.size(), 24);
    for (int i = 0; i < glog.size(); i++) begin
      want = (i == 0) ? 1 - g0 : 1 - glog[i-1];
      chk("rc_alternate", glog[i], want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
